// File: rtl/gray_pkg.sv
// gray_pkg: helpers shared by the Gray-code conversion blocks.
//   GRAY_MAX_W  widest supported code word
//   gray_to_bin prefix-XOR decode of a Gray word; bits at or above w are masked
//   popcount    number of set bits in a word (Hamming weight)
package gray_pkg;

  localparam int GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] gray_to_bin(
    input logic [GRAY_MAX_W-1:0] g,
    input int                    w
  );
    logic [GRAY_MAX_W-1:0] mask;
    logic [GRAY_MAX_W-1:0] gm;
    logic [GRAY_MAX_W-1:0] b;
    if (w >= GRAY_MAX_W) mask = '1;
    else                 mask = (GRAY_MAX_W'(1) << w) - GRAY_MAX_W'(1);
    gm = g & mask;
    // Masked upper bits are zero, so a full-width MSB-first prefix XOR
    // produces the correct WIDTH-bit decode in the low bits.
    b = '0;
    b[GRAY_MAX_W-1] = gm[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gm[i];
    end
    return b;
  endfunction

  function automatic logic [5:0] popcount(input logic [GRAY_MAX_W-1:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// gray2bin_comb: purely combinational Gray-to-binary decode.
//   i_gray  Gray-coded word
//   o_bin   binary equivalent
import gray_pkg::*;

module gray2bin_comb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  assign o_bin = WIDTH'(gray_to_bin(GRAY_MAX_W'(i_gray), WIDTH));

endmodule

// File: rtl/gray2bin_decoder.sv
// gray2bin_decoder: two-stage pipelined Gray-to-binary decoder with
// valid/ready flow control, per-word step-error flag and a saturating
// error counter.
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    input handshake, gray_in is the Gray word
//   out_valid/out_ready  output handshake, bin_out/out_err are the result
//   err_cnt              saturating count of errored words accepted
import gray_pkg::*;

module gray2bin_decoder #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  logic             r_s1_v;
  logic             r_s1_err;
  logic [WIDTH-1:0] r_s1_gray;
  logic             r_s2_v;
  logic             r_s2_err;
  logic [WIDTH-1:0] r_s2_bin;
  logic [WIDTH-1:0] r_prev_gray;
  logic             r_have_prev;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_in_xfer;
  logic [5:0]       w_dist;
  logic             w_step_err;
  logic [WIDTH-1:0] w_s1_bin;

  // A stage may load when it is empty or its content is moving on this cycle.
  assign w_s2_adv   = !r_s2_v || out_ready;
  assign w_s1_adv   = !r_s1_v || w_s2_adv;
  assign in_ready   = w_s1_adv;
  assign w_in_xfer  = in_valid && w_s1_adv;

  assign w_dist     = popcount(GRAY_MAX_W'(gray_in ^ r_prev_gray));
  assign w_step_err = r_have_prev && (w_dist >= 6'd2);

  gray2bin_comb #(.WIDTH(WIDTH)) u_dec (
    .i_gray (r_s1_gray),
    .o_bin  (w_s1_bin)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v      <= 1'b0;
      r_s1_err    <= 1'b0;
      r_s1_gray   <= '0;
      r_s2_v      <= 1'b0;
      r_s2_err    <= 1'b0;
      r_s2_bin    <= '0;
      r_prev_gray <= '0;
      r_have_prev <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_v <= in_valid;
        if (w_in_xfer) begin
          r_s1_gray <= gray_in;
          r_s1_err  <= w_step_err;
        end
      end
      // Output data only changes when a real word moves in, so it holds
      // stable under backpressure and across bubbles.
      if (w_s2_adv) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) begin
          r_s2_bin <= w_s1_bin;
          r_s2_err <= r_s1_err;
        end
      end
      if (w_in_xfer) begin
        r_prev_gray <= gray_in;
        r_have_prev <= 1'b1;
        if (w_step_err && (r_err_cnt != {CNT_W{1'b1}})) begin
          r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid = r_s2_v;
  assign bin_out   = r_s2_bin;
  assign out_err   = r_s2_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_gray2bin_decoder.sv
`timescale 1ns/1ps
module tb_gray2bin_decoder;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [3:0] gray_in, bin_out;
  logic [7:0] err_cnt;

  logic       s_rst, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_err;
  logic [3:0] s_gray, s_bin;
  logic [1:0] s_err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  gray2bin_decoder #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .gray_in(gray_in), .out_valid(out_valid), .out_ready(out_ready),
    .bin_out(bin_out), .out_err(out_err), .err_cnt(err_cnt)
  );

  gray2bin_decoder #(.WIDTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .gray_in(s_gray), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .bin_out(s_bin), .out_err(s_out_err), .err_cnt(s_err_cnt)
  );

  // Reference decode: binary value is the XOR of all right shifts of g.
  function automatic logic [3:0] ref_bin(input logic [3:0] g);
    int v, b;
    v = int'(g);
    b = 0;
    while (v != 0) begin
      b = b ^ v;
      v = v >> 1;
    end
    return 4'(b);
  endfunction

  typedef struct packed { logic [3:0] bin; logic err; } word_t;
  word_t exp_q[$];
  word_t act_q[$];

  logic [3:0] m_prev = '0;
  logic       m_have = 1'b0;
  logic       m_e;
  int         m_cnt = 0;
  int         m_occ = 0;
  logic       p_acc = 1'b0, p_out = 1'b0;
  logic [3:0] p_gray = '0;

  // Observe handshakes mid-cycle, apply them to the model at the edge.
  always @(negedge clk) begin
    p_acc  = !rst && in_valid && in_ready;
    p_out  = !rst && out_valid && out_ready;
    p_gray = gray_in;
    if (p_out) act_q.push_back(word_t'({bin_out, out_err}));
  end

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete(); act_q.delete();
      m_prev = '0; m_have = 1'b0; m_cnt = 0; m_occ = 0;
    end else begin
      if (p_acc) begin
        m_e = m_have && ($countones(p_gray ^ m_prev) >= 2);
        exp_q.push_back(word_t'({ref_bin(p_gray), m_e}));
        if (m_e && m_cnt < 255) m_cnt++;
        m_prev = p_gray;
        m_have = 1'b1;
        m_occ++;
      end
      if (p_out) m_occ--;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_words(input logic [3:0] w [8], input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; gray_in = w[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (bin_out !== 4'h0) begin n_fail++; $display("FAIL reset_bin_out: got %h want 0", bin_out); end
    n_tests++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    n_tests++; if (err_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_sequential();
    logic [3:0] g [5];
    logic [3:0] b [5];
    logic       ev;
    g = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
    b = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c < 5) begin in_valid = 1'b1; gray_in = g[c]; end
      else in_valid = 1'b0;
      @(negedge clk); #1;
      ev = (c >= 2 && c <= 6);
      n_tests++; if (out_valid !== ev) begin n_fail++; $display("FAIL seq_out_valid c=%0d: got %b want %b", c, out_valid, ev); end
      if (ev) begin
        n_tests++; if (bin_out !== b[c-2] || out_err !== 1'b0) begin n_fail++; $display("FAIL seq_word c=%0d: got bin=%b err=%b want bin=%b err=0", c, bin_out, out_err, b[c-2]); end
      end
      @(posedge clk); #1;
    end
    n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL seq_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_step_violation();
    logic [3:0] b [3];
    logic       e [3];
    b = '{4'b0000, 4'b0010, 4'b0101};
    e = '{1'b0, 1'b1, 1'b0};
    do_reset();
    send_words('{4'b0000, 4'b0011, 4'b0111, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}, 3);
    n_tests++; if (act_q.size() != 3) begin n_fail++; $display("FAIL step_count: got %0d want 3", act_q.size()); end
    for (int i = 0; i < 3 && i < act_q.size(); i++) begin
      n_tests++; if (act_q[i].bin !== b[i] || act_q[i].err !== e[i]) begin n_fail++; $display("FAIL step_word%0d: got bin=%b err=%b want bin=%b err=%b", i, act_q[i].bin, act_q[i].err, b[i], e[i]); end
    end
    n_tests++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL step_err_cnt: got %0d want 1", err_cnt); end
  endtask

  task automatic test_wrap();
    do_reset();
    send_words('{4'b1000, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}, 2);
    n_tests++; if (act_q.size() != 2) begin n_fail++; $display("FAIL wrap_count: got %0d want 2", act_q.size()); end
    else begin
      n_tests++; if (act_q[0] !== word_t'({4'b1111, 1'b0}) || act_q[1] !== word_t'({4'b0000, 1'b0})) begin n_fail++; $display("FAIL wrap_words: got %h %h want 1e 00", act_q[0], act_q[1]); end
    end
    do_reset();
    send_words('{4'b0101, 4'b0101, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}, 2);
    n_tests++; if (act_q.size() != 2) begin n_fail++; $display("FAIL hold_count: got %0d want 2", act_q.size()); end
    else begin
      n_tests++; if (act_q[0] !== word_t'({4'b0110, 1'b0}) || act_q[1] !== word_t'({4'b0110, 1'b0})) begin n_fail++; $display("FAIL hold_words: got %h %h want 0c 0c", act_q[0], act_q[1]); end
    end
    n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL hold_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_backpressure();
    logic [3:0] w0, w1, w2, held;
    int acc;
    w0 = 4'($urandom_range(0, 15));
    w1 = w0 ^ (4'b0001 << $urandom_range(0, 3));
    w2 = w1 ^ (4'b0001 << $urandom_range(0, 3));
    acc = 0; held = '0;
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      gray_in = (c == 0) ? w0 : (c == 1) ? w1 : w2;
      @(negedge clk); #1;
      if (in_ready) acc++;
      n_tests++; if (in_ready !== (c < 2)) begin n_fail++; $display("FAIL bp_in_ready c=%0d: got %b want %b", c, in_ready, (c < 2)); end
      if (c == 2) begin
        held = bin_out;
        n_tests++; if (out_valid !== 1'b1 || bin_out !== ref_bin(w0)) begin n_fail++; $display("FAIL bp_head: got v=%b bin=%b want v=1 bin=%b", out_valid, bin_out, ref_bin(w0)); end
      end
      if (c == 3) begin
        n_tests++; if (bin_out !== held || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got v=%b bin=%b want v=1 bin=%b", out_valid, bin_out, held); end
      end
      @(posedge clk); #1;
    end
    n_tests++; if (acc != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d want 2", acc); end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_tests++; if (act_q.size() != 2) begin n_fail++; $display("FAIL bp_drain_count: got %0d want 2", act_q.size()); end
    else begin
      n_tests++; if (act_q[0] !== word_t'({ref_bin(w0), 1'b0}) || act_q[1] !== word_t'({ref_bin(w1), 1'b0})) begin n_fail++; $display("FAIL bp_drain_order: got %h %h want %h %h", act_q[0], act_q[1], word_t'({ref_bin(w0), 1'b0}), word_t'({ref_bin(w1), 1'b0})); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] g;
    g = 4'($urandom_range(0, 15));
    do_reset();
    for (int c = 0; c < 24; c++) begin
      if (c < 20) begin
        in_valid = 1'b1;
        if ($urandom_range(0, 4) == 0) g = 4'($urandom_range(0, 15));
        else if ($urandom_range(0, 1) == 1) g = g ^ (4'b0001 << $urandom_range(0, 3));
        gray_in = g;
      end else in_valid = 1'b0;
      @(negedge clk); #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready c=%0d: got %b want 1", c, in_ready); end
      n_tests++; if (out_valid !== (c >= 2 && c < 22)) begin n_fail++; $display("FAIL b2b_out_valid c=%0d: got %b want %b", c, out_valid, (c >= 2 && c < 22)); end
      @(posedge clk); #1;
    end
    n_tests++; if (act_q.size() != 20 || exp_q.size() != 20) begin n_fail++; $display("FAIL b2b_count: got %0d want 20 (model %0d)", act_q.size(), exp_q.size()); end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_tests++; if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_word%0d: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    n_tests++; if (int'(err_cnt) != m_cnt) begin n_fail++; $display("FAIL b2b_err_cnt: got %0d want %0d", err_cnt, m_cnt); end
  endtask

  task automatic test_random();
    logic [3:0] g;
    logic       er;
    g = '0;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) g = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 1) == 1) g = g ^ (4'b0001 << $urandom_range(0, 3));
      gray_in = g;
      @(negedge clk); #1;
      er = (m_occ < 2) || out_ready;
      n_tests++; if (in_ready !== er) begin n_fail++; $display("FAIL rnd_in_ready c=%0d: got %b want %b", c, in_ready, er); end
      n_tests++; if (int'(err_cnt) != m_cnt) begin n_fail++; $display("FAIL rnd_err_cnt c=%0d: got %0d want %0d", c, err_cnt, m_cnt); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_tests++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_tests++; if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_word%0d: got %h want %h", i, act_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_saturation();
    logic [3:0] w [5];
    int ex;
    w = '{4'b0000, 4'b0011, 4'b0000, 4'b0011, 4'b0000};
    @(posedge clk); #1; s_rst = 1'b1; s_in_valid = 1'b0; s_out_ready = 1'b1;
    @(posedge clk); #1; s_rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) begin s_in_valid = 1'b1; s_gray = w[k]; end
      else s_in_valid = 1'b0;
      @(negedge clk); #1;
      ex = (k > 1) ? k - 1 : 0;
      if (ex > 3) ex = 3;
      n_tests++; if (int'(s_err_cnt) != ex) begin n_fail++; $display("FAIL sat_err_cnt k=%0d: got %0d want %0d", k, s_err_cnt, ex); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; gray_in = 4'b0000;
    @(posedge clk); #1;
    gray_in = 4'b0011;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); #1;
    n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL mid_full: got v=%b rdy=%b cnt=%0d want 1/0/1", out_valid, in_ready, err_cnt); end
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; gray_in = 4'b1010;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk); #1;
    n_tests++; if (out_valid !== 1'b0 || err_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_reset: got v=%b cnt=%0d want 0/0", out_valid, err_cnt); end
    n_tests++; if (bin_out !== 4'h0 || out_err !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_out: got bin=%b err=%b rdy=%b want 0000/0/1", bin_out, out_err, in_ready); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    send_words('{4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}, 1);
    n_tests++; if (act_q.size() != 1) begin n_fail++; $display("FAIL mid_after_count: got %0d want 1", act_q.size()); end
    else begin
      n_tests++; if (act_q[0] !== word_t'({4'b1010, 1'b0})) begin n_fail++; $display("FAIL mid_after_word: got %h want 14", act_q[0]); end
    end
    n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_after_cnt: got %0d want 0", err_cnt); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; gray_in = '0;
    s_rst = 1'b1; s_in_valid = 1'b0; s_out_ready = 1'b1; s_gray = '0;
    test_reset();
    test_sequential();
    test_step_violation();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
